// File: rtl/alu_shift_seq.sv
// Multi-cycle shift sequencer: steps an external single-bit-shift ALU
// shamt times, feeding each ALU result back as the next operand.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SLL
`define ALU_SLL 4'd5
`endif
`ifndef ALU_SRL
`define ALU_SRL 4'd6
`endif
`ifndef ALU_SLA
`define ALU_SLA 4'd7
`endif
`ifndef ALU_SRA
`define ALU_SRA 4'd8
`endif

module alu_shift_seq #(
  parameter int WORD_SIZE = `WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           sh_op,
  input  logic [WORD_SIZE-1:0] operand,
  input  logic [4:0]           shamt,
  input  logic                 abort,
  output logic [WORD_SIZE-1:0] alu_in_1,
  output logic [WORD_SIZE-1:0] alu_in_2,
  output logic [3:0]           alu_op,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic                 err,
  output logic                 zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [WORD_SIZE-1:0] acc;
  logic [3:0]           op;
  logic [4:0]           cnt;
  logic                 accept;
  logic                 op_ok;
  logic                 last;
  logic                 step;

  always_comb begin
    op_ok  = (sh_op == `ALU_SLL) || (sh_op == `ALU_SRL) ||
             (sh_op == `ALU_SLA) || (sh_op == `ALU_SRA);
    accept = start && (state != RUN);
    last   = (cnt == 5'd1);
    step   = (state == RUN) && !abort;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (!accept)
          state_nx = IDLE;
        else if (op_ok && (shamt != 5'd0))
          state_nx = RUN;
        else
          state_nx = DONE;
      end
      RUN: begin
        if (abort)
          state_nx = IDLE;
        else if (last)
          state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Abort leaves every register untouched, including acc and cnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      op     <= `ALU_SLL;
      cnt    <= 5'd0;
      result <= '0;
      zero   <= 1'b1;
      err    <= 1'b0;
    end else if (accept) begin
      acc <= operand;
      op  <= sh_op;
      cnt <= shamt;
      if (!op_ok || (shamt == 5'd0)) begin
        result <= operand;
        zero   <= (operand == '0);
        err    <= !op_ok;
      end
    end else if (step) begin
      acc <= alu_out;
      cnt <= cnt - 5'd1;
      if (last) begin
        result <= alu_out;
        zero   <= (alu_out == '0);
        err    <= 1'b0;
      end
    end
  end

  assign alu_in_1 = acc;
  assign alu_in_2 = '0;
  assign alu_op   = op;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_alu_shift_seq.sv
// Scoreboard bench for alu_shift_seq with a behavioural
// single-step shift ALU closing the loop.
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SLL
`define ALU_SLL 4'd5
`endif
`ifndef ALU_SRL
`define ALU_SRL 4'd6
`endif
`ifndef ALU_SLA
`define ALU_SLA 4'd7
`endif
`ifndef ALU_SRA
`define ALU_SRA 4'd8
`endif

module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  sh_op = `ALU_SLL;
  logic [31:0] operand = '0;
  logic [4:0]  shamt = '0;
  logic        abort = 1'b0;
  logic [31:0] alu_in_1;
  logic [31:0] alu_in_2;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;
  logic        zero;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        e;
    int          edge_no;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   busy_cnt = 0;
  int   edge_n = 0;

  alu_shift_seq #(.WORD_SIZE(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sh_op    (sh_op),
    .operand  (operand),
    .shamt    (shamt),
    .abort    (abort),
    .alu_in_1 (alu_in_1),
    .alu_in_2 (alu_in_2),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .err      (err),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference ALU: one-bit shift step; SLA behaves as a logical left shift.
  always_comb begin
    case (alu_op)
      `ALU_SLL, `ALU_SLA: alu_out = alu_in_1 << 1;
      `ALU_SRL:           alu_out = alu_in_1 >> 1;
      `ALU_SRA:           alu_out = $unsigned($signed(alu_in_1) >>> 1);
      default:            alu_out = alu_in_1 + alu_in_2;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (busy) busy_cnt++;
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("done_edge", edge_n, e.edge_no);
            chk("result", result, e.res);
            chk("zero", {31'd0, zero}, {31'd0, e.z});
            chk("err", {31'd0, err}, {31'd0, e.e});
            chk("alu_in_2", alu_in_2, 32'd0);
          end
        end
      end
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] opnd,
                       input logic [4:0] sh, input logic [31:0] res,
                       input logic er);
    exp_t e;
    int   k;
    bit   ok;
    k  = edge_n + 1;
    ok = (op == `ALU_SLL) || (op == `ALU_SRL) ||
         (op == `ALU_SLA) || (op == `ALU_SRA);
    e.res     = res;
    e.z       = (res == 32'd0);
    e.e       = er;
    e.edge_no = k + ((ok && sh != 5'd0) ? int'(sh) : 0);
    q.push_back(e);
    start   = 1'b1;
    sh_op   = op;
    operand = opnd;
    shamt   = sh;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_acc", alu_in_1, 32'd0);
    chk("rst_op", {28'd0, alu_op}, {28'd0, `ALU_SLL});
    reset = 1'b0;

    issue(`ALU_SLL, 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b0);
    drain();

    busy_cnt = 0;
    issue(`ALU_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);
    drain();
    chk("srl31_busy_cycles", busy_cnt, 31);

    busy_cnt = 0;
    issue(`ALU_SLL, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
    drain();
    chk("shamt0_busy", busy_cnt, 0);

    issue(`ALU_ADD, 32'h0000_1234, 5'd3, 32'h0000_1234, 1'b1);
    drain();
    issue(`ALU_SRA, 32'h8000_0010, 5'd4, 32'hF800_0001, 1'b0);
    drain();
    issue(`ALU_SLA, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0);
    drain();

    // Abort at the third RUN edge with a competing start.
    start   = 1'b1;
    sh_op   = `ALU_SLL;
    operand = 32'h0000_0001;
    shamt   = 5'd8;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_run", {31'd0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    abort   = 1'b1;
    start   = 1'b1;
    operand = 32'h0000_0055;
    shamt   = 5'd0;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'h0000_000C);
    chk("abort_err", {31'd0, err}, 32'd0);
    busy_cnt = 0;
    repeat (12) @(negedge clk);
    chk("abort_start_ignored", busy_cnt, 0);

    issue(`ALU_SLL, 32'h8000_0000, 5'd1, 32'h0000_0000, 1'b0);
    @(negedge clk);
    issue(`ALU_SRL, 32'h0000_00F0, 5'd4, 32'h0000_000F, 1'b0);
    drain();

    // Asynchronous reset in the middle of a run.
    issue(`ALU_SLL, 32'h0000_0001, 5'd10, 32'h0000_0400, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    q.delete();
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_result", result, 32'd0);
    chk("areset_zero", {31'd0, zero}, 32'd1);
    chk("areset_acc", alu_in_1, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(`ALU_SRL, 32'h0000_0100, 5'd8, 32'h0000_0001, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
